// File: rtl/regfile_wb_queue.sv
// ============================================================================
//  Module   : regfile_wb_queue
//  Purpose  : In-order writeback queue feeding the single write port of the
//             32x32 register file. Accepts ALU and load writebacks (load has
//             priority), retires one entry per cycle, publishes a pending-write
//             mask for RAW hazard detection.
//  Options  : REGFILE_WB_BYPASS_EN - adds a two-port combinational lookup that
//             returns the youngest queued value for a source register.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_wb_queue #(
    parameter int DEPTH = 4,
    parameter int XLEN  = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    alu_valid,
    input  logic [4:0]              alu_rd,
    input  logic [XLEN-1:0]         alu_data,
    output logic                    alu_ready,
    input  logic                    ld_valid,
    input  logic [4:0]              ld_rd,
    input  logic [XLEN-1:0]         ld_data,
    output logic                    ld_ready,
    output logic                    rf_we,
    output logic [4:0]              rf_rd,
    output logic [XLEN-1:0]         rf_wdata,
    output logic [31:0]             pend_mask,
    output logic [$clog2(DEPTH):0]  q_count
`ifdef REGFILE_WB_BYPASS_EN
    ,
    input  logic [4:0]              byp_rs1,
    input  logic [4:0]              byp_rs2,
    output logic                    byp_hit1,
    output logic                    byp_hit2,
    output logic [XLEN-1:0]         byp_data1,
    output logic [XLEN-1:0]         byp_data2
`endif
);

    localparam int PTR_W = $clog2(DEPTH);

    // Queue storage and bookkeeping
    logic [4:0]       rd_mem_q   [DEPTH];
    logic [XLEN-1:0]  data_mem_q [DEPTH];
    logic [DEPTH-1:0] valid_q;
    logic [PTR_W-1:0] head_q;
    logic [PTR_W-1:0] tail_q;
    logic [PTR_W:0]   count_q;
    logic [PTR_W:0]   count_d;

    logic             w_not_full;
    logic             w_ld_take;
    logic             w_alu_take;
    logic             w_push;
    logic             w_pop;
    logic [4:0]       w_push_rd;
    logic [XLEN-1:0]  w_push_data;

    // Ready is based on the registered count only; a same-cycle pop never
    // opens a slot for a push (keeps ready off the retire path).
    assign w_not_full = (count_q < (PTR_W+1)'(DEPTH));
    assign ld_ready   = !rst && w_not_full;
    assign alu_ready  = !rst && w_not_full && !ld_valid;

    assign w_ld_take  = ld_valid && ld_ready;
    assign w_alu_take = alu_valid && alu_ready;

    // Select the accepted request; writes to x0 finish the handshake but are dropped
    always_comb begin
        w_push_rd   = 5'd0;
        w_push_data = '0;
        w_push      = 1'b0;
        if (w_ld_take) begin
            w_push_rd   = ld_rd;
            w_push_data = ld_data;
            w_push      = (ld_rd != 5'd0);
        end else if (w_alu_take) begin
            w_push_rd   = alu_rd;
            w_push_data = alu_data;
            w_push      = (alu_rd != 5'd0);
        end
    end

    // Head entry drives the register file; reset suppresses any in-flight commit
    assign w_pop    = !rst && (count_q != '0);
    assign rf_we    = w_pop;
    assign rf_rd    = rd_mem_q[head_q];
    assign rf_wdata = data_mem_q[head_q];
    assign q_count  = count_q;

    // Occupancy: push and pop together leave it unchanged
    always_comb begin
        count_d = count_q;
        if (w_push && !w_pop) begin
            count_d = count_q + 1'b1;
        end else if (!w_push && w_pop) begin
            count_d = count_q - 1'b1;
        end
    end

    // Pointer, valid and occupancy update; pointers wrap naturally (DEPTH is 2^n)
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            valid_q <= '0;
        end else begin
            if (w_pop) begin
                valid_q[head_q] <= 1'b0;
                head_q          <= head_q + 1'b1;
            end
            if (w_push) begin
                valid_q[tail_q] <= 1'b1;
                tail_q          <= tail_q + 1'b1;
            end
            count_q <= count_d;
        end
    end

    // Entry payload capture; payload needs no reset because valid_q qualifies it
    always_ff @(posedge clk) begin
        if (!rst && w_push) begin
            rd_mem_q[tail_q]   <= w_push_rd;
            data_mem_q[tail_q] <= w_push_data;
        end
    end

    // Pending-write mask: decoded rd of every valid entry; x0 is never pending
    always_comb begin
        pend_mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i]) begin
                pend_mask[rd_mem_q[i]] = 1'b1;
            end
        end
        pend_mask[0] = 1'b0;
    end

`ifdef REGFILE_WB_BYPASS_EN
    // Bypass lookup: walk oldest to youngest so the youngest match wins
    always_comb begin
        logic [PTR_W-1:0] idx;
        byp_hit1  = 1'b0;
        byp_hit2  = 1'b0;
        byp_data1 = '0;
        byp_data2 = '0;
        idx       = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head_q + PTR_W'(i);
            if (valid_q[idx] && (rd_mem_q[idx] == byp_rs1) && (byp_rs1 != 5'd0)) begin
                byp_hit1  = 1'b1;
                byp_data1 = data_mem_q[idx];
            end
            if (valid_q[idx] && (rd_mem_q[idx] == byp_rs2) && (byp_rs2 != 5'd0)) begin
                byp_hit2  = 1'b1;
                byp_data2 = data_mem_q[idx];
            end
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_regfile_wb_queue.sv
// ============================================================================
//  Module   : tb_regfile_wb_queue
//  Purpose  : Directed, table-driven bench for regfile_wb_queue, plus hand
//             sequences for reset-mid-queue and same-register ordering.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_regfile_wb_queue;

    logic        clk;
    logic        rst;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        alu_ready;
    logic        ld_valid;
    logic [4:0]  ld_rd;
    logic [31:0] ld_data;
    logic        ld_ready;
    logic        rf_we;
    logic [4:0]  rf_rd;
    logic [31:0] rf_wdata;
    logic [31:0] pend_mask;
    logic [2:0]  q_count;
`ifdef REGFILE_WB_BYPASS_EN
    logic [4:0]  byp_rs1;
    logic [4:0]  byp_rs2;
    logic        byp_hit1;
    logic        byp_hit2;
    logic [31:0] byp_data1;
    logic [31:0] byp_data2;
`endif

    regfile_wb_queue #(.DEPTH(4), .XLEN(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .alu_valid (alu_valid),
        .alu_rd    (alu_rd),
        .alu_data  (alu_data),
        .alu_ready (alu_ready),
        .ld_valid  (ld_valid),
        .ld_rd     (ld_rd),
        .ld_data   (ld_data),
        .ld_ready  (ld_ready),
        .rf_we     (rf_we),
        .rf_rd     (rf_rd),
        .rf_wdata  (rf_wdata),
        .pend_mask (pend_mask),
        .q_count   (q_count)
`ifdef REGFILE_WB_BYPASS_EN
        ,
        .byp_rs1   (byp_rs1),
        .byp_rs2   (byp_rs2),
        .byp_hit1  (byp_hit1),
        .byp_hit2  (byp_hit2),
        .byp_data1 (byp_data1),
        .byp_data2 (byp_data2)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file model: records every commit the DUT makes
    logic [31:0] rf_model [32];
    int          n_writes;
    always @(posedge clk) begin
        if (rf_we === 1'b1) begin
            rf_model[rf_rd] <= rf_wdata;
            n_writes        <= n_writes + 1;
        end
    end

    typedef struct {
        logic        rst;
        logic        lv;
        logic [4:0]  lrd;
        logic [31:0] ldat;
        logic        av;
        logic [4:0]  ard;
        logic [31:0] adat;
        logic        e_ldr;
        logic        e_alr;
        logic        e_we;
        logic [4:0]  e_rd;
        logic [31:0] e_wd;
        logic [31:0] e_pend;
        logic [2:0]  e_cnt;
    } vec_t;

    localparam int NVEC = 21;
    vec_t vt [NVEC];

    int checks;
    int errors;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic r, input logic lv, input logic [4:0] lrd,
                         input logic [31:0] ldat, input logic av, input logic [4:0] ard,
                         input logic [31:0] adat);
        rst       = r;
        ld_valid  = lv;
        ld_rd     = lrd;
        ld_data   = ldat;
        alu_valid = av;
        alu_rd    = ard;
        alu_data  = adat;
    endtask

    task automatic setv(input int i, input logic r, input logic lv, input logic [4:0] lrd,
                        input logic [31:0] ldat, input logic av, input logic [4:0] ard,
                        input logic [31:0] adat, input logic eldr, input logic ealr,
                        input logic ewe, input logic [4:0] erd, input logic [31:0] ewd,
                        input logic [31:0] epend, input logic [2:0] ecnt);
        vt[i].rst = r;     vt[i].lv = lv;     vt[i].lrd = lrd;   vt[i].ldat = ldat;
        vt[i].av = av;     vt[i].ard = ard;   vt[i].adat = adat;
        vt[i].e_ldr = eldr; vt[i].e_alr = ealr; vt[i].e_we = ewe;
        vt[i].e_rd = erd;  vt[i].e_wd = ewd;  vt[i].e_pend = epend; vt[i].e_cnt = ecnt;
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        n_writes = 0;
        for (int r = 0; r < 32; r++) rf_model[r] = 32'h0;
`ifdef REGFILE_WB_BYPASS_EN
        byp_rs1 = 5'd0;
        byp_rs2 = 5'd0;
`endif

        // ---- vector table: checks taken just before the edge closing each cycle ----
        //   idx rst lv lrd  ldat        av ard  adat         ldr alr we rd  wd           pend         cnt
        // reset held with a pending ALU request
        setv(0, 1, 0, 0, 0,            1, 5, 32'h1,         0, 0, 0, 0, 0,            32'h0,       0);
        // single ALU write x5, retires the next cycle
        setv(1, 0, 0, 0, 0,            1, 5, 32'hDEADBEEF,  1, 1, 0, 0, 0,            32'h0,       0);
        setv(2, 0, 0, 0, 0,            0, 0, 0,             1, 1, 1, 5, 32'hDEADBEEF, 32'h20,      1);
        setv(3, 0, 0, 0, 0,            0, 0, 0,             1, 1, 0, 0, 0,            32'h0,       0);
        // load and ALU together: load wins, ALU follows
        setv(4, 0, 1, 7, 32'h11,       1, 8, 32'h22,        1, 0, 0, 0, 0,            32'h0,       0);
        setv(5, 0, 0, 0, 0,            1, 8, 32'h22,        1, 1, 1, 7, 32'h11,       32'h80,      1);
        setv(6, 0, 0, 0, 0,            0, 0, 0,             1, 1, 1, 8, 32'h22,       32'h100,     1);
        setv(7, 0, 0, 0, 0,            0, 0, 0,             1, 1, 0, 0, 0,            32'h0,       0);
        // write to x0 is discarded
        setv(8, 0, 0, 0, 0,            1, 0, 32'h5,         1, 1, 0, 0, 0,            32'h0,       0);
        setv(9, 0, 0, 0, 0,            0, 0, 0,             1, 1, 0, 0, 0,            32'h0,       0);
        // eight cycles of load+ALU: ALU starved, loads retire in order
        for (int k = 0; k < 8; k++) begin
            if (k == 0)
                setv(10, 0, 1, 5'd10, 32'h100, 1, 20, 32'hA1, 1, 0, 0, 0, 0, 32'h0, 0);
            else
                setv(10 + k, 0, 1, 5'(10 + k), 32'h100 + k, 1, 20, 32'hA1,
                     1, 0, 1, 5'(9 + k), 32'h100 + k - 1, 32'h1 << (9 + k), 1);
        end
        setv(18, 0, 0, 0, 0,           1, 20, 32'hA1,       1, 1, 1, 17, 32'h107,     32'h20000,   1);
        setv(19, 0, 0, 0, 0,           0, 0, 0,             1, 1, 1, 20, 32'hA1,      32'h100000,  1);
        setv(20, 0, 0, 0, 0,           0, 0, 0,             1, 1, 0, 0, 0,            32'h0,       0);

        // first reset edge with no checks (state is unknown before it)
        drive(1, 0, 0, 0, 1, 5, 32'h1);
        @(posedge clk);

        for (int i = 0; i < NVEC; i++) begin
            @(negedge clk);
            drive(vt[i].rst, vt[i].lv, vt[i].lrd, vt[i].ldat, vt[i].av, vt[i].ard, vt[i].adat);
            #1;
            check($sformatf("v%0d ld_ready", i),  {31'b0, ld_ready},  {31'b0, vt[i].e_ldr});
            check($sformatf("v%0d alu_ready", i), {31'b0, alu_ready}, {31'b0, vt[i].e_alr});
            check($sformatf("v%0d rf_we", i),     {31'b0, rf_we},     {31'b0, vt[i].e_we});
            check($sformatf("v%0d pend_mask", i), pend_mask,          vt[i].e_pend);
            check($sformatf("v%0d q_count", i),   {29'b0, q_count},   {29'b0, vt[i].e_cnt});
            if (vt[i].e_we) begin
                check($sformatf("v%0d rf_rd", i),    {27'b0, rf_rd}, {27'b0, vt[i].e_rd});
                check($sformatf("v%0d rf_wdata", i), rf_wdata,       vt[i].e_wd);
            end
        end

        // ---- reset mid-queue: x3=A commits, x3=B is dropped ----
        @(negedge clk);
        drive(0, 0, 0, 0, 1, 3, 32'hA);
        #1;
        check("r6 accept A", {31'b0, alu_ready}, 32'h1);
        @(negedge clk);
        drive(0, 0, 0, 0, 1, 3, 32'hB);
        #1;
        check("r6 we A",    {31'b0, rf_we}, 32'h1);
        check("r6 wdata A", rf_wdata,       32'hA);
        check("r6 pend x3", pend_mask,      32'h8);
        @(negedge clk);
        drive(1, 0, 0, 0, 0, 0, 0);
        #1;
        check("r6 we during rst", {31'b0, rf_we},     32'h0);
        check("r6 ldr during rst", {31'b0, ld_ready}, 32'h0);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0);
        #1;
        check("r6 cnt after rst",  {29'b0, q_count}, 32'h0);
        check("r6 pend after rst", pend_mask,        32'h0);
        check("r6 we after rst",   {31'b0, rf_we},   32'h0);
        check("r6 x3 kept A",      rf_model[3],      32'hA);
        check("r6 write count",    n_writes,         32'd13);

        // ---- same sequence without reset: younger x3=B wins ----
        @(negedge clk);
        drive(0, 0, 0, 0, 1, 3, 32'hA);
        @(negedge clk);
        drive(0, 0, 0, 0, 1, 3, 32'hB);
        #1;
        check("s6 wdata A", rf_wdata, 32'hA);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0);
`ifdef REGFILE_WB_BYPASS_EN
        byp_rs1 = 5'd3;
        byp_rs2 = 5'd0;
`endif
        #1;
        check("s6 we B",    {31'b0, rf_we}, 32'h1);
        check("s6 wdata B", rf_wdata,       32'hB);
        check("s6 pend x3", pend_mask,      32'h8);
`ifdef REGFILE_WB_BYPASS_EN
        check("s6 hit1",  {31'b0, byp_hit1}, 32'h1);
        check("s6 data1", byp_data1,         32'hB);
        check("s6 hit2 x0", {31'b0, byp_hit2}, 32'h0);
        check("s6 data2 x0", byp_data2,        32'h0);
`endif
        @(negedge clk);
        #1;
        check("s6 we idle", {31'b0, rf_we}, 32'h0);
`ifdef REGFILE_WB_BYPASS_EN
        check("s6 hit1 empty",  {31'b0, byp_hit1}, 32'h0);
        check("s6 data1 empty", byp_data1,         32'h0);
`endif

        // ---- final register file contents: nothing lost, order respected ----
        check("rf x3", rf_model[3], 32'hB);
        check("rf x5", rf_model[5], 32'hDEADBEEF);
        check("rf x7", rf_model[7], 32'h11);
        check("rf x8", rf_model[8], 32'h22);
        check("rf x0", rf_model[0], 32'h0);
        for (int r = 10; r < 18; r++) begin
            check($sformatf("rf x%0d", r), rf_model[r], 32'h100 + (r - 10));
        end
        check("rf x20",       rf_model[20], 32'hA1);
        check("total writes", n_writes,     32'd15);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
